// File: rtl/snake_engine.sv
// Snake game engine: cell-map playfield, head/tail walking, LFSR-driven apple placement.
// Optional score counter enabled by defining SNAKE_SCORE_EN (score tied to 0 otherwise).
module snake_engine #(
  parameter  int SIZE_X   = 10,
  parameter  int SIZE_Y   = 10,
  parameter  int WRAP     = 0,
  parameter  int INIT_LEN = 4,
  parameter  int SCORE_W  = 8,
  localparam int N        = SIZE_X * SIZE_Y,
  localparam int SBITS    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step,
  input  logic [1:0]         snake_dir,
  input  logic [SBITS-1:0]   seed,
  output logic [3*N-1:0]     field,
  output logic [SBITS-1:0]   apple_pos,
  output logic               busy,
  output logic               game_over,
  output logic               won,
  output logic [SCORE_W-1:0] score
);

  localparam int CW      = 7;
  localparam int LW      = 16;
  localparam int APPLE_I = (SIZE_Y / 2) * SIZE_X + SIZE_X / 2;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PLACE, S_DEAD, S_WIN} state_t;

  state_t           r_state, w_next;
  logic [2:0]       r_field [N];
  logic [CW-1:0]    r_hx, r_hy, r_tx, r_ty;
  logic [1:0]       r_dir;
  logic [LW-1:0]    r_lfsr;
  logic [SBITS-1:0] r_ptr, r_cnt, r_apple_pos;
  logic             r_busy, r_game_over, r_won;

  logic [1:0]       w_dir, w_tail_dir;
  logic [CW-1:0]    w_nx, w_ny, w_ntx, w_nty;
  logic [SBITS-1:0] w_head_idx, w_new_idx, w_tail_idx, w_ptr_inc;
  logic [2:0]       w_target, w_tail_code, w_code;
  logic             w_oob, w_eat, w_body, w_dead, w_move, w_commit, w_slot_free, w_fb;

  function automatic logic [SBITS-1:0] cell_idx(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return SBITS'(32'(y) * 32'(SIZE_X) + 32'(x));
  endfunction

  function automatic logic [CW-1:0] nxt_x(input logic [CW-1:0] x, input logic [1:0] d);
    logic [CW-1:0] v;
    case (d)
      2'd1:    v = (x == CW'(SIZE_X - 1)) ? CW'(0) : x + CW'(1);
      2'd3:    v = (x == CW'(0)) ? CW'(SIZE_X - 1) : x - CW'(1);
      default: v = x;
    endcase
    return v;
  endfunction

  function automatic logic [CW-1:0] nxt_y(input logic [CW-1:0] y, input logic [1:0] d);
    logic [CW-1:0] v;
    case (d)
      2'd0:    v = (y == CW'(0)) ? CW'(SIZE_Y - 1) : y - CW'(1);
      2'd2:    v = (y == CW'(SIZE_Y - 1)) ? CW'(0) : y + CW'(1);
      default: v = y;
    endcase
    return v;
  endfunction

  function automatic logic [2:0] init_cell(input int i);
    logic [2:0] c;
    if ((i / SIZE_X) == 1 && (i % SIZE_X) >= 1 && (i % SIZE_X) <= INIT_LEN) begin
      c = 3'd2;
    end else if (i == APPLE_I) begin
      c = 3'd5;
    end else begin
      c = 3'd0;
    end
    return c;
  endfunction

  // A reversal request keeps the latched heading; the tail follows its own stored code.
  assign w_dir       = (snake_dir == (r_dir ^ 2'b10)) ? r_dir : snake_dir;
  assign w_nx        = nxt_x(r_hx, w_dir);
  assign w_ny        = nxt_y(r_hy, w_dir);
  assign w_oob       = (WRAP == 0) &&
                       ((w_dir == 2'd0 && r_hy == CW'(0)) ||
                        (w_dir == 2'd1 && r_hx == CW'(SIZE_X - 1)) ||
                        (w_dir == 2'd2 && r_hy == CW'(SIZE_Y - 1)) ||
                        (w_dir == 2'd3 && r_hx == CW'(0)));
  assign w_head_idx  = cell_idx(r_hx, r_hy);
  assign w_new_idx   = cell_idx(w_nx, w_ny);
  assign w_tail_idx  = cell_idx(r_tx, r_ty);
  assign w_target    = r_field[w_new_idx];
  assign w_eat       = (w_target == 3'd5);
  assign w_body      = (w_target >= 3'd1) && (w_target <= 3'd4);
  assign w_dead      = w_oob || (w_body && (w_new_idx != w_tail_idx));
  assign w_tail_code = r_field[w_tail_idx];
  assign w_tail_dir  = 2'(w_tail_code - 3'd1);
  assign w_ntx       = nxt_x(r_tx, w_tail_dir);
  assign w_nty       = nxt_y(r_ty, w_tail_dir);
  assign w_code      = {1'b0, w_dir} + 3'd1;
  assign w_move      = (r_state == S_RUN) && step && !start;
  assign w_commit    = w_move && !w_dead;
  assign w_slot_free = (r_field[r_ptr] == 3'd0);
  assign w_ptr_inc   = (r_ptr == SBITS'(N - 1)) ? SBITS'(0) : r_ptr + SBITS'(1);
  assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Next-state decode
  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = S_RUN;
    end else begin
      case (r_state)
        S_RUN: begin
          if (step) begin
            if (w_dead)     w_next = S_DEAD;
            else if (w_eat) w_next = S_PLACE;
            else            w_next = S_RUN;
          end else begin
            w_next = S_RUN;
          end
        end
        S_PLACE: begin
          if (w_slot_free)                   w_next = S_RUN;
          else if (r_cnt == SBITS'(N - 1))   w_next = S_WIN;
          else                               w_next = S_PLACE;
        end
        default: w_next = r_state;
      endcase
    end
  end

  // State register and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_game_over <= 1'b0;
      r_won       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next == S_PLACE);
      r_game_over <= (w_next == S_DEAD);
      r_won       <= (w_next == S_WIN);
    end
  end

  // Head/tail/heading, LFSR and placement scan pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hx        <= CW'(0);
      r_hy        <= CW'(0);
      r_tx        <= CW'(0);
      r_ty        <= CW'(0);
      r_dir       <= 2'd0;
      r_lfsr      <= LW'(1);
      r_ptr       <= SBITS'(0);
      r_cnt       <= SBITS'(0);
      r_apple_pos <= SBITS'(0);
    end else if (start) begin
      r_hx        <= CW'(INIT_LEN);
      r_hy        <= CW'(1);
      r_tx        <= CW'(1);
      r_ty        <= CW'(1);
      r_dir       <= 2'd1;
      r_lfsr      <= (seed == SBITS'(0)) ? LW'(1) : LW'(seed);
      r_apple_pos <= SBITS'(APPLE_I);
    end else begin
      r_lfsr <= {r_lfsr[LW-2:0], w_fb};
      if (w_commit) begin
        r_dir <= w_dir;
        r_hx  <= w_nx;
        r_hy  <= w_ny;
        if (w_eat) begin
          r_ptr <= SBITS'(32'(r_lfsr) % 32'(N));
          r_cnt <= SBITS'(0);
        end else begin
          r_tx <= w_ntx;
          r_ty <= w_nty;
        end
      end else if (r_state == S_PLACE) begin
        if (w_slot_free) begin
          r_apple_pos <= r_ptr;
        end else begin
          r_ptr <= w_ptr_inc;
          r_cnt <= r_cnt + SBITS'(1);
        end
      end
    end
  end

  // Cell map; the new-head write comes last so it wins when the head enters the old tail cell
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_field[i] <= 3'd0;
    end else if (start) begin
      for (int i = 0; i < N; i++) r_field[i] <= init_cell(i);
    end else if (w_commit) begin
      r_field[w_head_idx] <= w_code;
      if (!w_eat) begin
        r_field[w_tail_idx] <= 3'd0;
      end
      r_field[w_new_idx] <= w_code;
    end else if (r_state == S_PLACE && w_slot_free) begin
      r_field[r_ptr] <= 3'd5;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_field
    assign field[gi*3 +: 3] = r_field[gi];
  end

  assign apple_pos = r_apple_pos;
  assign busy      = r_busy;
  assign game_over = r_game_over;
  assign won       = r_won;

`ifdef SNAKE_SCORE_EN
  logic [SCORE_W-1:0] r_score;

  // Saturating apple counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_score <= SCORE_W'(0);
    end else if (start) begin
      r_score <= SCORE_W'(0);
    end else if (w_commit && w_eat && (r_score != {SCORE_W{1'b1}})) begin
      r_score <= r_score + SCORE_W'(1);
    end
  end

  assign score = r_score;
`else
  assign score = SCORE_W'(0);
`endif

endmodule

// File: tb/tb_snake_engine.sv
// Randomised bench for snake_engine: three instances (10x10 walls, 10x10 wrap, 4x4 walls)
// checked against a queue-of-segments reference model.
module tb_snake_engine;

  typedef logic [299:0] vec_t;
  localparam int M_IDLE = 0, M_RUN = 1, M_PLACE = 2, M_DEAD = 3, M_WIN = 4;

  logic clk = 1'b0;
  logic rst, start, step;
  logic [1:0] dir;
  logic [6:0] seed;

  logic [299:0] field_a, field_b;
  logic [47:0]  field_c;
  logic [6:0]   ap_a, ap_b;
  logic [3:0]   ap_c;
  logic         busy_a, busy_b, busy_c, over_a, over_b, over_c, won_a, won_b, won_c;
  logic [7:0]   sc_a, sc_b, sc_c;

  snake_engine #(.SIZE_X(10), .SIZE_Y(10), .WRAP(0), .INIT_LEN(4), .SCORE_W(8)) u_a (
    .clk(clk), .rst(rst), .start(start), .step(step), .snake_dir(dir), .seed(seed),
    .field(field_a), .apple_pos(ap_a), .busy(busy_a), .game_over(over_a), .won(won_a), .score(sc_a));
  snake_engine #(.SIZE_X(10), .SIZE_Y(10), .WRAP(1), .INIT_LEN(4), .SCORE_W(8)) u_b (
    .clk(clk), .rst(rst), .start(start), .step(step), .snake_dir(dir), .seed(seed),
    .field(field_b), .apple_pos(ap_b), .busy(busy_b), .game_over(over_b), .won(won_b), .score(sc_b));
  snake_engine #(.SIZE_X(4), .SIZE_Y(4), .WRAP(0), .INIT_LEN(2), .SCORE_W(8)) u_c (
    .clk(clk), .rst(rst), .start(start), .step(step), .snake_dir(dir), .seed(seed[3:0]),
    .field(field_c), .apple_pos(ap_c), .busy(busy_c), .game_over(over_c), .won(won_c), .score(sc_c));

  always #5 clk = ~clk;

  int sel;
  logic [299:0] o_field;
  logic [6:0]   o_apple;
  logic         o_busy, o_over, o_won;
  logic [7:0]   o_score;

  assign o_field = (sel == 0) ? field_a : (sel == 1) ? field_b : {252'd0, field_c};
  assign o_apple = (sel == 0) ? ap_a : (sel == 1) ? ap_b : {3'd0, ap_c};
  assign o_busy  = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
  assign o_over  = (sel == 0) ? over_a : (sel == 1) ? over_b : over_c;
  assign o_won   = (sel == 0) ? won_a : (sel == 1) ? won_b : won_c;
  assign o_score = (sel == 0) ? sc_a : (sel == 1) ? sc_b : sc_c;

  int n_cmp = 0, n_bad = 0;
  int sx, sy, wrp, ilen, ncell;
  int snake[$];
  int head_code, cur_dir, mstate, mscore, apple;
  int ham[16] = '{2, 3, 3, 3, 1, 1, 2, 0, 2, 3, 3, 0, 1, 1, 1, 0};

  task automatic chk(input string tag, input vec_t obs, input vec_t exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int dir_code(int from, int to);
    int dx, dy;
    dx = (to % sx - from % sx + sx) % sx;
    dy = (to / sx - from / sx + sy) % sy;
    if (dx == 1) return 2;
    if (dx == sx - 1) return 4;
    if (dy == 1) return 3;
    return 1;
  endfunction

  function automatic vec_t exp_field();
    vec_t f = '0;
    for (int k = 0; k < snake.size(); k++)
      f[snake[k]*3 +: 3] = 3'((k == 0) ? head_code : dir_code(snake[k], snake[k-1]));
    if (apple >= 0) f[apple*3 +: 3] = 3'd5;
    return f;
  endfunction

  function automatic bit occupied(int c);
    foreach (snake[k]) if (snake[k] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic compare_all(input string tag);
    int es;
`ifdef SNAKE_SCORE_EN
    es = mscore;
`else
    es = 0;
`endif
    chk({tag, ".field"}, o_field, exp_field());
    chk({tag, ".flags"}, vec_t'({o_won, o_over, o_busy}),
        vec_t'({mstate == M_WIN, mstate == M_DEAD, mstate == M_PLACE}));
    chk({tag, ".score"}, vec_t'(o_score), vec_t'(es));
    if (apple >= 0) chk({tag, ".apple"}, vec_t'(o_apple), vec_t'(apple));
  endtask

  task automatic use_dut(input int s);
    sel   = s;
    sx    = (s == 2) ? 4 : 10;
    sy    = sx;
    wrp   = (s == 1) ? 1 : 0;
    ilen  = (s == 2) ? 2 : 4;
    ncell = sx * sy;
  endtask

  task automatic model_start();
    snake.delete();
    for (int x = ilen; x >= 1; x--) snake.push_back(sx + x);
    head_code = 2;
    cur_dir   = 1;
    apple     = (sy / 2) * sx + sx / 2;
    mscore    = 0;
    mstate    = M_RUN;
  endtask

  task automatic model_step(input int d);
    int eff, nx, ny, n, lim;
    bit eat;
    if (mstate != M_RUN) return;
    eff = (d == (cur_dir + 2) % 4) ? cur_dir : d;
    cur_dir = eff;
    nx = snake[0] % sx + ((eff == 1) ? 1 : (eff == 3) ? -1 : 0);
    ny = snake[0] / sx + ((eff == 2) ? 1 : (eff == 0) ? -1 : 0);
    if (wrp == 0 && (nx < 0 || nx >= sx || ny < 0 || ny >= sy)) begin
      mstate = M_DEAD;
      return;
    end
    nx  = (nx + sx) % sx;
    ny  = (ny + sy) % sy;
    n   = ny * sx + nx;
    eat = (n == apple);
    lim = eat ? snake.size() : snake.size() - 1;
    for (int k = 0; k < lim; k++) begin
      if (snake[k] == n) begin
        mstate = M_DEAD;
        return;
      end
    end
    if (!eat) void'(snake.pop_back());
    snake.push_front(n);
    head_code = eff + 1;
    if (eat) begin
      apple = -1;
      if (mscore < 255) mscore++;
      mstate = M_PLACE;
    end
  endtask

  // Placement: first free cell at or after an unknown start point, found one cell per cycle.
  task automatic do_place();
    int cyc = 0;
    int skipped = 0;
    while (o_busy && cyc < ncell + 2) begin
      cyc++;
      step = 1'($urandom_range(0, 1));
      dir  = 2'($urandom_range(0, 3));
      tick();
      step = 1'b0;
    end
    if (snake.size() == ncell) begin
      chk("win_latency", vec_t'(cyc), vec_t'(ncell));
      mstate = M_WIN;
    end else begin
      chk("place_latency", vec_t'(cyc >= 1 && cyc <= ncell), vec_t'(1));
      chk("apple_on_empty", vec_t'(occupied(int'(o_apple)) || int'(o_apple) >= ncell), vec_t'(0));
      for (int k = 1; k < cyc; k++)
        if (!occupied((int'(o_apple) - k + ncell) % ncell)) skipped++;
      chk("scan_order", vec_t'(skipped), vec_t'(0));
      apple  = int'(o_apple);
      mstate = M_RUN;
    end
    compare_all("place");
  endtask

  task automatic do_start();
    seed  = 7'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    model_start();
    compare_all("start");
  endtask

  task automatic do_step(input int d);
    dir  = 2'(d);
    step = 1'b1;
    tick();
    step = 1'b0;
    model_step(d);
    compare_all("step");
    if (mstate == M_PLACE) do_place();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; step = 1'b0; dir = 2'd0; seed = 7'd0;
    use_dut(0);
    snake.delete(); mstate = M_IDLE; apple = -1; mscore = 0; cur_dir = 1; head_code = 0;
    #12;
    compare_all("reset");
    chk("reset.apple_pos", vec_t'(o_apple), vec_t'(0));
    rst = 1'b0;
    tick();
    repeat (3) do_step($urandom_range(0, 3));

    // start beats a simultaneous step
    seed = 7'd0; start = 1'b1; step = 1'b1; dir = 2'd2;
    tick();
    start = 1'b0; step = 1'b0;
    model_start();
    compare_all("start_prio");

    do_start();
    repeat (3) do_step(1);
    chk("run3.head_cell", vec_t'(o_field[(10 + 7)*3 +: 3]), vec_t'(2));

    do_start();
    do_step(3);

    do_start();
    repeat (5) do_step(1);
    do_step(1);
    chk("wall.game_over", vec_t'(o_over), vec_t'(1));
    repeat (2) do_step($urandom_range(0, 3));
    do_start();

    do_start();
    repeat (4) do_step(2);
    do_step(1);

    for (int i = 0; i < 250; i++) begin
      do_step($urandom_range(0, 3));
      if (mstate == M_DEAD || mstate == M_WIN) do_start();
    end

    use_dut(1);
    do_start();
    repeat (6) do_step(1);
    chk("wrap.head_cell", vec_t'(o_field[10*3 +: 3]), vec_t'(2));
    for (int i = 0; i < 250; i++) begin
      do_step($urandom_range(0, 3));
      if (mstate == M_DEAD || mstate == M_WIN) do_start();
    end

    // Follow a Hamiltonian cycle until the 4x4 board is full
    use_dut(2);
    do_start();
    for (int g = 0; g < 600 && mstate == M_RUN; g++) do_step(ham[snake[0]]);
    chk("full.won", vec_t'(o_won), vec_t'(1));
    chk("full.busy", vec_t'(o_busy), vec_t'(0));
    do_step($urandom_range(0, 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/snake_engine.md
SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 SHALL have parameters (name, default, meaning):
 SIZE_X  10  field columns, 4..64
 SIZE_Y  10  field rows, 4..64
 WRAP  0  0 = walls kill, 1 = toroidal edges
 INIT_LEN  4  initial snake length, 2..SIZE_X-2
 SCORE_W  8  score counter width
REQ-002 SHALL have ports (name, direction, width, meaning); N = SIZE_X*SIZE_Y, SBITS = clog2(N):
 clk  in  1  clock, rising edge
 rst  in  1  asynchronous active-high reset
 start  in  1  (re)initialise game
 step  in  1  advance snake one cell
 snake_dir  in  2  requested direction: 0 up, 1 right, 2 down, 3 left
 seed  in  SBITS  apple-placement seed, sampled on start
 field  out  3*N  cell map, 3 bits per cell, index (y*SIZE_X+x)*3
 apple_pos  out  SBITS  linear index of current apple
 busy  out  1  apple placement in progress
 game_over  out  1  snake died
 won  out  1  no empty cell left for an apple
 score  out  SCORE_W  apples eaten
REQ-003 SHALL encode cells as: 0 empty, 1 up, 2 right, 3 down, 4 left, 5 apple; body cells point toward the next segment headward.

Function
REQ-004 SHALL implement an FSM with states IDLE, RUN, PLACE, DEAD, WIN; game_over = (DEAD), won = (WIN), busy = (PLACE).
REQ-005 start SHALL, from any state, on the next edge: clear field; write cells (1..INIT_LEN, 1) = 2; set tail (1,1), head (INIT_LEN,1), direction right; write apple 5 at (SIZE_X/2, SIZE_Y/2); set apple_pos; load placement LFSR with seed (0 replaced by 1); clear score; enter RUN.
REQ-006 start SHALL take priority over step in the same cycle.
REQ-007 step SHALL be acted upon only in RUN; in IDLE, PLACE, DEAD and WIN it SHALL be ignored and not queued.
REQ-008 On an accepted step, snake_dir SHALL replace the latched direction unless it is the exact reverse, in which case the latched direction is kept; the move uses the resulting direction.
REQ-009 field, head, tail, score and state SHALL reflect the move on the edge accepting the step (1-cycle latency).
REQ-010 WRAP=0: a move leaving the grid SHALL enter DEAD with field unchanged; WRAP=1: coordinates SHALL wrap modulo SIZE_X / SIZE_Y.
REQ-011 A move into a body cell SHALL enter DEAD with field unchanged, except the current tail cell, which is legal when no apple is eaten.
REQ-012 Normal move: old head cell gets the direction code, new head cell gets the direction code, tail cell cleared, tail advances along its code.
REQ-013 Apple move: head written as in REQ-012, tail unchanged, score increments (saturating at all-ones), FSM enters PLACE.
REQ-014 PLACE: pointer = LFSR value mod N on entry; one cell per cycle; empty cell -> write 5, update apple_pos, return to RUN; occupied -> pointer+1, wrapping N-1 -> 0.
REQ-015 PLACE SHALL enter WIN after N consecutive occupied cells checked; placement latency is 1..N cycles.
REQ-016 LFSR SHALL advance every clock in all states so placement depends on step timing.
REQ-017 start during PLACE SHALL abort placement and reinitialise per REQ-005.

Reset
REQ-018 rst SHALL asynchronously force: field 0, apple_pos 0, score 0, busy 0, game_over 0, won 0, state IDLE, head/tail/direction 0, LFSR 1.
REQ-019 rst deassertion SHALL leave the block in IDLE until start.

Configuration
REQ-020 Macro SNAKE_SCORE_EN defined: score counts per REQ-013; undefined: no score register, score tied to 0, all other behaviour identical.

Verification
REQ-021 rst, start, 3 steps dir=1 (10x10) -> head (7,1), tail (4,1), cells (4..7,1)=2, (1..3,1)=0, state RUN.
REQ-022 After start, step dir=3 -> reverse ignored, head (5,1), snake_dir latched right.
REQ-023 WRAP=0, steer head to x=9 and step dir=1 -> game_over=1, field frozen; further steps ignored; start -> RUN.
REQ-024 WRAP=1, same sequence -> head (0,y), game_over=0.
REQ-025 Steer head onto apple (5,5) -> length+1, score=1, busy=1 for >=1 cycle, new apple on an empty cell, steps during busy ignored.
REQ-026 4x4 field, fill 15 cells with snake, eat last apple -> PLACE scans 16 cells, then won=1, busy=0.
